// File: rtl/camera_frame_writer.sv
// camera_frame_writer: samples the OV7670 parallel bus (RGB565, two bytes per
// pixel) in the system clock domain, packs each pixel to RGB332 and writes it
// into the frame buffer at y*WIDTH+x. Reports frame completion and geometry errors.
module camera_frame_writer #(
  parameter int WIDTH  = 176,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] LP_XMAX = XW'(WIDTH);
  localparam logic [YW-1:0] LP_YMAX = YW'(HEIGHT);

  typedef enum logic {
    ST_WAIT_FRAME,
    ST_ACTIVE
  } state_t;

  // synchronisers
  logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic       r_href_s1, r_href_s2, r_href_s3;
  logic       r_vsync_s1, r_vsync_s2, r_vsync_s3;
  logic [7:0] r_data_s1, r_data_s2;

  // capture state
  state_t              r_state, w_state;
  logic [XW-1:0]       r_x, w_x;
  logic [YW-1:0]       r_y, w_y;
  logic                r_phase, w_phase;
  logic [5:0]          r_hi, w_hi;        // only the RGB565 bits that survive packing
  logic                r_line_err, w_line_err;
  logic                r_wen, w_wen;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [7:0]          r_wdata, w_wdata;
  logic                r_done, w_done;
  logic                r_err, w_err;

  logic                w_pclk_rise;
  logic                w_href_fall;
  logic                w_vsync_fall;
  logic                w_vsync_rise;
  logic [ADDR_W-1:0]   w_pix_addr;

  assign w_pclk_rise  =  r_pclk_s2  & ~r_pclk_s3;
  assign w_href_fall  = ~r_href_s2  &  r_href_s3;
  assign w_vsync_fall = ~r_vsync_s2 &  r_vsync_s3;
  assign w_vsync_rise =  r_vsync_s2 & ~r_vsync_s3;
  assign w_pix_addr   = ADDR_W'(r_y) * ADDR_W'(WIDTH) + ADDR_W'(r_x);

  // Bring the asynchronous camera signals into the CLK domain, keep a third PCLK/HREF/VSYNC stage for edges
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pclk_s1  <= 1'b0; r_pclk_s2  <= 1'b0; r_pclk_s3  <= 1'b0;
      r_href_s1  <= 1'b0; r_href_s2  <= 1'b0; r_href_s3  <= 1'b0;
      r_vsync_s1 <= 1'b0; r_vsync_s2 <= 1'b0; r_vsync_s3 <= 1'b0;
      r_data_s1  <= '0;   r_data_s2  <= '0;
    end else begin
      r_pclk_s1  <= CAM_PCLK;   r_pclk_s2  <= r_pclk_s1;  r_pclk_s3  <= r_pclk_s2;
      r_href_s1  <= CAM_HREF;   r_href_s2  <= r_href_s1;  r_href_s3  <= r_href_s2;
      r_vsync_s1 <= CAM_VSYNC;  r_vsync_s2 <= r_vsync_s1; r_vsync_s3 <= r_vsync_s2;
      r_data_s1  <= CAM_DATA;   r_data_s2  <= r_data_s1;
    end
  end

  // State and capture registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_WAIT_FRAME;
      r_x        <= '0;
      r_y        <= '0;
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_line_err <= 1'b0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_x        <= w_x;
      r_y        <= w_y;
      r_phase    <= w_phase;
      r_hi       <= w_hi;
      r_line_err <= w_line_err;
      r_wen      <= w_wen;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  // Next-state: events in one cycle are applied in order PCLK rise, HREF fall, VSYNC rise,
  // each stage reading the values updated by the previous one
  always_comb begin
    w_state    = r_state;
    w_x        = r_x;
    w_y        = r_y;
    w_phase    = r_phase;
    w_hi       = r_hi;
    w_line_err = r_line_err;
    w_wen      = 1'b0;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_done     = 1'b0;
    w_err      = r_err;

    case (r_state)
      ST_WAIT_FRAME: begin
        if (w_vsync_fall) begin
          w_state    = ST_ACTIVE;
          w_x        = '0;
          w_y        = '0;
          w_phase    = 1'b0;
          w_line_err = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (w_pclk_rise && r_href_s2) begin
          if (!r_phase) begin
            w_hi    = {r_data_s2[7:5], r_data_s2[2:0]};
            w_phase = 1'b1;
          end else begin
            w_phase = 1'b0;
            if ((r_x < LP_XMAX) && (r_y < LP_YMAX)) begin
              w_wen   = 1'b1;
              w_addr  = w_pix_addr;
              w_wdata = {r_hi, r_data_s2[4:3]};
              w_x     = r_x + XW'(1);
            end else begin
              w_line_err = 1'b1;
            end
          end
        end

        if (w_href_fall) begin
          if (w_x != '0) begin
            if (w_y < LP_YMAX) begin
              w_y = w_y + YW'(1);
            end
            if (w_x < LP_XMAX) begin
              w_line_err = 1'b1;
            end
          end
          if (w_phase) begin
            w_line_err = 1'b1;
          end
          w_x     = '0;
          w_phase = 1'b0;
        end

        if (w_vsync_rise) begin
          w_done  = 1'b1;
          w_err   = w_line_err | (w_y != LP_YMAX);
          w_state = ST_WAIT_FRAME;
        end
      end

      default: w_state = ST_WAIT_FRAME;
    endcase
  end

  assign W_EN       = r_wen;
  assign W_ADDR     = r_addr;
  assign W_DATA     = r_wdata;
  assign FRAME_DONE = r_done;
  assign FRAME_ERR  = r_err;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer. A reduced 12x10 geometry keeps each
// frame short; every expected write is queued as its pixel is driven and popped
// when W_EN is seen.
module tb_camera_frame_writer;

  localparam int W  = 12;
  localparam int H  = 10;
  localparam int AW = 7;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CAM_PCLK;
  logic          CAM_HREF;
  logic          CAM_VSYNC;
  logic [7:0]    CAM_DATA;
  logic          W_EN;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          FRAME_DONE;
  logic          FRAME_ERR;

  camera_frame_writer #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CAM_PCLK   (CAM_PCLK),
    .CAM_HREF   (CAM_HREF),
    .CAM_VSYNC  (CAM_VSYNC),
    .CAM_DATA   (CAM_DATA),
    .W_EN       (W_EN),
    .W_ADDR     (W_ADDR),
    .W_DATA     (W_DATA),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  n_wr     = 0;
  int  n_done   = 0;
  int  wr_base  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

  // Output monitor: every write must match the oldest queued expectation
  always @(negedge CLK) begin
    wr_t e;
    if (W_EN === 1'b1) begin
      n_wr++;
      check("wen_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("w_addr", 32'(W_ADDR), e.addr);
        check("w_data", 32'(W_DATA), 32'(e.data));
      end
    end
    if (FRAME_DONE === 1'b1) n_done++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    CAM_PCLK = 1'b0;
    CAM_DATA = b;
    tick(2);
    CAM_PCLK = 1'b1;
    tick(2);
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo,
                            input bit en, input int addr, input logic [7:0] d);
    wr_t e;
    send_byte(hi);
    if (en) begin
      e.addr = addr;
      e.data = d;
      sb.push_back(e);
    end
    send_byte(lo);
  endtask

  task automatic line_start();
    CAM_PCLK = 1'b0;
    tick(2);
    CAM_HREF = 1'b1;
    tick(2);
  endtask

  task automatic line_end();
    CAM_PCLK = 1'b0;
    tick(2);
    CAM_HREF = 1'b0;
    tick(6);
  endtask

  task automatic send_line(input int y, input int npix, input bit odd, input bit en);
    line_start();
    for (int x = 0; x < npix; x++)
      send_pixel(8'(x), 8'(y), en && (x < W) && (y < H), y * W + x, pack(8'(x), 8'(y)));
    if (odd) send_byte(8'hA5);
    line_end();
  endtask

  task automatic frame_start();
    CAM_VSYNC = 1'b1;
    tick(4);
    wr_base   = n_wr;
    CAM_VSYNC = 1'b0;
    tick(8);
  endtask

  task automatic frame_end(input string tag, input int exp_writes, input bit exp_err);
    int d0;
    d0 = n_done;
    CAM_VSYNC = 1'b1;
    for (int i = 0; i < 20 && n_done == d0; i++) tick(1);
    tick(4);
    check({tag, "_done_cnt"}, n_done - d0, 1);
    check({tag, "_frame_err"}, 32'(FRAME_ERR), 32'(exp_err));
    check({tag, "_writes"}, n_wr - wr_base, exp_writes);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic nominal(input string tag);
    frame_start();
    for (int y = 0; y < H; y++) send_line(y, W, 1'b0, 1'b1);
    frame_end(tag, W * H, 1'b0);
  endtask

  initial begin
    int d0;
    int wr0;
    RESET     = 1'b1;
    CAM_PCLK  = 1'b0;
    CAM_HREF  = 1'b0;
    CAM_VSYNC = 1'b1;
    CAM_DATA  = 8'h00;
    tick(4);
    check("rst_w_en",       32'(W_EN), 0);
    check("rst_w_addr",     32'(W_ADDR), 0);
    check("rst_w_data",     32'(W_DATA), 0);
    check("rst_frame_done", 32'(FRAME_DONE), 0);
    check("rst_frame_err",  32'(FRAME_ERR), 0);
    RESET = 1'b0;
    tick(4);

    nominal("nom1");

    // line 0 carries W+4 pixels; the extras must be dropped
    frame_start();
    send_line(0, W + 4, 1'b0, 1'b1);
    for (int y = 1; y < H; y++) send_line(y, W, 1'b0, 1'b1);
    frame_end("long", W * H, 1'b1);

    // short frame, then the error level must hold until the next frame ends
    frame_start();
    for (int y = 0; y < 6; y++) send_line(y, W, 1'b0, 1'b1);
    frame_end("short", 6 * W, 1'b1);
    CAM_VSYNC = 1'b0;
    tick(20);
    check("err_hold", 32'(FRAME_ERR), 1);

    nominal("nom2");

    // line 2 has a dangling odd byte
    frame_start();
    for (int y = 0; y < H; y++) send_line(y, W, (y == 2), 1'b1);
    frame_end("odd", W * H, 1'b1);

    // reset after 5 pixels of line 3
    frame_start();
    for (int y = 0; y < 3; y++) send_line(y, W, 1'b0, 1'b1);
    line_start();
    for (int x = 0; x < 5; x++) send_pixel(8'(x), 8'd3, 1'b1, 3 * W + x, pack(8'(x), 8'd3));
    tick(8);
    check("mid_sb_drained", sb.size(), 0);
    d0  = n_done;
    wr0 = n_wr;
    RESET = 1'b1;
    tick(3);
    check("mid_rst_w_en",       32'(W_EN), 0);
    check("mid_rst_w_addr",     32'(W_ADDR), 0);
    check("mid_rst_w_data",     32'(W_DATA), 0);
    check("mid_rst_frame_done", 32'(FRAME_DONE), 0);
    check("mid_rst_frame_err",  32'(FRAME_ERR), 0);
    RESET = 1'b0;
    for (int x = 5; x < W; x++) send_pixel(8'(x), 8'd3, 1'b0, 0, 8'h00);
    line_end();
    for (int y = 4; y < 6; y++) send_line(y, W, 1'b0, 1'b0);
    CAM_VSYNC = 1'b1;
    tick(12);
    check("mid_no_writes", n_wr - wr0, 0);
    check("mid_no_done",   n_done - d0, 0);
    check("mid_err_level", 32'(FRAME_ERR), 0);

    nominal("nom3");

    // packing vectors at the start of line 0
    frame_start();
    line_start();
    send_pixel(8'hF8, 8'h1F, 1'b1, 0, 8'hE3);
    send_pixel(8'h07, 8'hE0, 1'b1, 1, 8'h1C);
    send_pixel(8'hFF, 8'hFF, 1'b1, 2, 8'hFF);
    for (int x = 3; x < W; x++) send_pixel(8'(x), 8'd0, 1'b1, x, pack(8'(x), 8'd0));
    line_end();
    for (int y = 1; y < H; y++) send_line(y, W, 1'b0, 1'b1);
    frame_end("pack", W * H, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
